// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: md_op encodings,
// FSM states, the HI/LO result payload and the combinational arithmetic.
package mult_div_unit_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 3;

  // md_op encodings, also decoded by the hazard unit
  localparam logic [OP_W-1:0] MD_NONE  = 3'd0;
  localparam logic [OP_W-1:0] MD_MULT  = 3'd1;
  localparam logic [OP_W-1:0] MD_MULTU = 3'd2;
  localparam logic [OP_W-1:0] MD_DIV   = 3'd3;
  localparam logic [OP_W-1:0] MD_DIVU  = 3'd4;
  localparam logic [OP_W-1:0] MD_MTHI  = 3'd5;
  localparam logic [OP_W-1:0] MD_MTLO  = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // True for the multi-cycle arithmetic ops (mult/multu/div/divu)
  function automatic logic md_is_arith(input logic [OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the ops that use the multiplier rather than the divider
  function automatic logic md_is_mult(input logic [OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  // HI/LO result of an arithmetic op. Signed division works on magnitudes and
  // restores signs afterwards, which also yields 0x80000000 / -1 = 0x80000000.
  // A zero divisor is replaced by 1 only to keep the datapath X-free; the
  // caller suppresses the write-back in that case.
  function automatic hilo_t md_compute(input logic [OP_W-1:0] op,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    hilo_t             res;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic              sgn;

    prod  = '0;
    a_mag = a;
    b_mag = b;
    sgn   = (op == MD_DIV);

    case (op)
      MD_MULT:  prod = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{b[XLEN-1]}}, b});
      MD_MULTU: prod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
      default:  prod = '0;
    endcase

    if (sgn && a[XLEN-1]) a_mag = XLEN'(~a + XLEN'(1));
    if (sgn && b[XLEN-1]) b_mag = XLEN'(~b + XLEN'(1));
    if (b_mag == '0)      b_mag = XLEN'(1);

    quo = a_mag / b_mag;
    rem = a_mag % b_mag;
    if (sgn && (a[XLEN-1] ^ b[XLEN-1])) quo = XLEN'(~quo + XLEN'(1));
    if (sgn && a[XLEN-1])               rem = XLEN'(~rem + XLEN'(1));

    if (md_is_mult(op)) begin
      res.hi = prod[2*XLEN-1:XLEN];
      res.lo = prod[XLEN-1:0];
    end else begin
      res.hi = rem;
      res.lo = quo;
    end
    return res;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with HI/LO registers.
// Accepts mult/multu/div/divu (start) and mthi/mtlo from E, holds Busy for a
// fixed number of cycles per op, then commits the result to HI/LO.
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   start          - E-stage instruction is mult/multu/div/divu
//   md_op[2:0]     - operation code (see mult_div_unit_pkg)
//   A, B[31:0]     - forwarded rs / rt operands
//   flush          - kills this cycle's start / mthi / mtlo
//   Busy           - operation in flight (registered)
//   HI, LO[31:0]   - architectural HI/LO registers
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  md_state_e        state_q;
  md_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  hilo_t            res_q;
  logic             res_wr_q;

  logic             start_ok_c;
  logic             mthi_ok_c;
  logic             mtlo_ok_c;
  logic             done_c;
  logic             div_zero_c;
  logic [CNT_W-1:0] cnt_load_c;
  hilo_t            res_c;

  // Request qualification and per-op setup
  always_comb begin
    start_ok_c = 1'b0;
    mthi_ok_c  = 1'b0;
    mtlo_ok_c  = 1'b0;
    done_c     = 1'b0;
    div_zero_c = 1'b0;
    cnt_load_c = CNT_W'(DIV_CYCLES - 1);
    res_c      = md_compute(md_op, A, B);

    if (state_q == ST_IDLE && !flush) begin
      start_ok_c = start && md_is_arith(md_op);
      mthi_ok_c  = (md_op == MD_MTHI);
      mtlo_ok_c  = (md_op == MD_MTLO);
    end
    if (state_q == ST_BUSY && cnt_q == '0) done_c = 1'b1;
    if (!md_is_mult(md_op) && B == '0)     div_zero_c = 1'b1;
    if (md_is_mult(md_op))                 cnt_load_c = CNT_W'(MULT_CYCLES - 1);
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok_c) state_d = ST_BUSY;
      ST_BUSY: if (done_c)     state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Counter, held result, Busy and HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      res_q    <= '0;
      res_wr_q <= 1'b0;
      Busy     <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      if (start_ok_c) begin
        cnt_q    <= cnt_load_c;
        res_q    <= res_c;
        res_wr_q <= !div_zero_c;
        Busy     <= 1'b1;
      end else if (state_q == ST_BUSY) begin
        if (done_c) begin
          Busy <= 1'b0;
          if (res_wr_q) begin
            HI <= res_q.hi;
            LO <= res_q.lo;
          end
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end

      if (mthi_ok_c) HI <= A;
      if (mtlo_ok_c) LO <= A;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO and busy length are
// queued when an op is issued and compared when Busy drops.
module tb_mult_div_unit;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        flush = 1'b0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .flush (flush),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result using 64-bit host arithmetic
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    e.hi = m_hi;
    e.lo = m_lo;
    e.cyc = (op == OP_MULT || op == OP_MULTU) ? 5 : 10;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT: begin
        sq = sa * sb;
        p  = 64'(sq);
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      OP_DIV: if (b != 0) begin
        sq = sa / sb;
        sr = sa % sb;
        e.lo = 32'(sq); e.hi = 32'(sr);
      end
      OP_DIVU: if (b != 0) begin
        e.lo = a / b; e.hi = a % b;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit flush_mid, input bit mt_mid);
    exp_t e;
    int   cnt;
    sb_q.push_back(model(op, a, b));
    @(negedge clk);
    start = 1'b1; md_op = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0; A = '0; B = '0;
    cnt = 0;
    while (Busy && cnt < 100) begin
      cnt++;
      flush = flush_mid && (cnt == 2);
      if (mt_mid && cnt == 3) begin
        md_op = OP_MTLO; A = 32'hDEAD_BEEF;
      end else begin
        md_op = 3'd0; A = '0;
      end
      @(posedge clk); #1;
    end
    flush = 1'b0; md_op = 3'd0; A = '0;
    e = sb_q.pop_front();
    check({tag, "_cycles"}, 64'(cnt), 64'(e.cyc));
    check({tag, "_hi"}, 64'(HI), 64'(e.hi));
    check({tag, "_lo"}, 64'(LO), 64'(e.lo));
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    md_op = op; A = a;
    @(posedge clk); #1;
    md_op = 3'd0; A = '0;
    if (op == OP_MTHI) m_hi = a;
    else               m_lo = a;
    check({tag, "_busy"}, 64'(Busy), 64'(0));
    check({tag, "_hi"}, 64'(HI), 64'(m_hi));
    check({tag, "_lo"}, 64'(LO), 64'(m_lo));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", 64'(Busy), 64'(0));
    check("rst_hi", 64'(HI), 64'(0));
    check("rst_lo", 64'(LO), 64'(0));

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    check("mult_neg_hi_const", 64'(HI), 64'hFFFF_FFFF);
    check("mult_neg_lo_const", 64'(LO), 64'hFFFF_FFFA);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    check("divu_hi_const", 64'(HI), 64'd2);
    check("divu_lo_const", 64'(LO), 64'd14);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_hi_const", 64'(HI), 64'hFFFF_FFFF);
    check("div_lo_const", 64'(LO), 64'hFFFF_FFFD);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("div_ovf_lo_const", 64'(LO), 64'h8000_0000);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);

    run_mt("mthi", OP_MTHI, 32'h1234_5678);
    run_mt("mtlo", OP_MTLO, 32'h0000_0009);

    // start killed by flush
    @(negedge clk);
    start = 1'b1; md_op = OP_MULT; A = 32'd7; B = 32'd9; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0; A = '0; B = '0; flush = 1'b0;
    check("flush_start_busy", 64'(Busy), 64'(0));
    repeat (6) @(posedge clk);
    #1;
    check("flush_start_busy_late", 64'(Busy), 64'(0));
    check("flush_start_hi", 64'(HI), 64'(m_hi));
    check("flush_start_lo", 64'(LO), 64'(m_lo));

    run_op("mult_flush_mid", OP_MULT, 32'd1234, 32'hFFFF_FF00, 1'b1, 1'b0);

    // reset during the third busy cycle of a divide
    @(negedge clk);
    start = 1'b1; md_op = OP_DIV; A = 32'd100; B = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid_busy_pre", 64'(Busy), 64'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("rst_mid_busy", 64'(Busy), 64'(0));
    check("rst_mid_hi", 64'(HI), 64'(0));
    check("rst_mid_lo", 64'(LO), 64'(0));
    repeat (12) @(posedge clk);
    #1;
    check("rst_mid_discard_lo", 64'(LO), 64'(0));
    run_mt("mthi_after_rst", OP_MTHI, 32'hCAFE_0001);

    // divide by zero leaves HI/LO, mtlo while busy is ignored
    run_mt("mthi5", OP_MTHI, 32'd5);
    run_mt("mtlo6", OP_MTLO, 32'd6);
    run_op("div_zero", OP_DIV, 32'd77, 32'd0, 1'b0, 1'b1);
    check("div_zero_hi_const", 64'(HI), 64'd5);
    check("div_zero_lo_const", 64'(LO), 64'd6);
    run_op("divu_zero", OP_DIVU, 32'hFFFF_0000, 32'd0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  op;
      logic [31:0] ra, rb;
      op = 3'($urandom_range(1, 4));
      ra = $urandom;
      rb = (i == 5) ? 32'hFFFF_FFF0 : 32'($urandom);
      run_op($sformatf("rand%0d", i), op, ra, rb, 1'b0, 1'b0);
    end

    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
